// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunked adder: FSM state encoding,
// default slice width and the counter-width helper.
package adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int CHUNK_DEFAULT = 4;

    // A counter must stay at least one bit wide even when only one chunk exists.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple-carry slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_n.sv
// N-bit combinational ripple-carry slice built from full_adder cells; also
// exposes the carry into the top bit so the caller can derive signed overflow.
module rca_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         Cmsb
);

    logic [N:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (S[i]),
            .cout (c[i+1])
        );
    end

    assign Cout = c[N];
    assign Cmsb = c[N-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands summed CHUNK bits per clock
// through one ripple-carry slice, behind a start/busy/done handshake.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_bits(NCHUNK);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] acc;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] acc_next;
    logic             last_chunk;
    int               lo;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        lo       = int'(cnt) * CHUNK;
        slice_a  = a_q[lo +: CHUNK];
        slice_b  = b_q[lo +: CHUNK];
        acc_next = acc;
        acc_next[lo +: CHUNK] = slice_s;
    end

    assign last_chunk = (cnt == CW'(NCHUNK - 1));

    rca_n #(.N(CHUNK)) u_slice (
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_q),
        .S    (slice_s),
        .Cout (slice_cout),
        .Cmsb (slice_cmsb)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the datapath registers are reset along with the FSM so an
    // aborted operation leaves no stale operands or partial sum behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc     <= '0;
            S       <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        a_q     <= A;
                        // Subtract is A + ~B + ~Cin, so the inversion is folded in at accept.
                        b_q     <= B ^ {WIDTH{sub}};
                        carry_q <= Cin ^ sub;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc     <= acc_next;
                    carry_q <= slice_cout;
                    if (last_chunk) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                        S     <= acc_next;
                        Cout  <= slice_cout;
                        Ovf   <= slice_cmsb ^ slice_cout;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: a 4-bit-slice instance for the main
// vectors and handshake corners, and a single-chunk instance.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic [15:0] A, B;
    logic        Cin, sub;
    logic        busy, done, Cout, Ovf;
    logic [15:0] S;
    logic        busy2, done2, Cout2, Ovf2;
    logic [15:0] S2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin), .sub(sub),
        .busy(busy), .done(done), .S(S), .Cout(Cout), .Ovf(Ovf)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(A), .B(B), .Cin(Cin), .sub(sub),
        .busy(busy2), .done(done2), .S(S2), .Cout(Cout2), .Ovf(Ovf2)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sb;
        logic [15:0] exp_s;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one op and count edges (accept edge included) until done is seen.
    task automatic run_op(input bit use16, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sb, output int lat);
        A = a; B = b; Cin = cin; sub = sb;
        if (use16) start2 = 1'b1; else start = 1'b1;
        tick;
        start = 1'b0; start2 = 1'b0;
        lat = 1;
        while (!(use16 ? done2 : done) && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    initial begin
        int  lat;
        bit  saw_done;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        #3;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset S",    S,    0);
        check("reset Cout", Cout, 0);
        check("reset Ovf",  Ovf,  0);
        tick; tick;
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb, lat);
            check($sformatf("vec%0d latency", i), lat, 5);
            check($sformatf("vec%0d S", i),    S,    vecs[i].exp_s);
            check($sformatf("vec%0d Cout", i), Cout, vecs[i].exp_cout);
            check($sformatf("vec%0d Ovf", i),  Ovf,  vecs[i].exp_ovf);
            tick;
            check($sformatf("vec%0d done pulse", i), done, 0);
            check($sformatf("vec%0d S held", i),     S,    vecs[i].exp_s);
        end

        // start during RUN is ignored; start held in DONE is accepted back-to-back.
        A = 16'h7FFF; B = 16'h0001; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        check("run busy after accept", busy, 1);
        tick;
        A = 16'h0F0F; B = 16'h0F0F; sub = 1'b1; start = 1'b1;
        tick;
        start = 1'b0; A = 16'h0000; B = 16'h0000; sub = 1'b0;
        lat = 3;
        while (!done && lat < 20) begin tick; lat++; end
        check("ignore-start latency", lat, 5);
        check("ignore-start S",   S,   16'h8000);
        check("ignore-start Ovf", Ovf, 1);
        A = 16'h0005; B = 16'h0007; Cin = 1'b0; sub = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        check("b2b busy", busy, 1);
        check("b2b done", done, 0);
        check("b2b S held during run", S, 16'h8000);
        lat = 1;
        while (!done && lat < 20) begin tick; lat++; end
        check("b2b latency", lat, 5);
        check("b2b S",    S,    16'hFFFE);
        check("b2b Cout", Cout, 0);
        tick;

        // Reset in the second RUN cycle aborts without a done pulse.
        A = 16'h00FF; B = 16'h0001; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort S",    S,    0);
        check("abort Cout", Cout, 0);
        check("abort Ovf",  Ovf,  0);
        tick;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (done || busy) saw_done = 1'b1;
        end
        check("abort no done", saw_done, 0);
        run_op(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, lat);
        check("post-abort latency", lat, 5);
        check("post-abort S", S, 16'h3333);
        tick;

        // Single-chunk instance: same handshake, one RUN cycle.
        run_op(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, lat);
        check("c16 latency", lat, 2);
        check("c16 S",    S2,    16'h5556);
        check("c16 Cout", Cout2, 0);
        check("c16 Ovf",  Ovf2,  0);
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        check("c16 sub S",   S2,   16'h7FFF);
        check("c16 sub Ovf", Ovf2, 1);
        tick;
        check("c16 done pulse", done2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
